// File: rtl/spike_count_classifier.sv
// Spike-count output decoder: counts spikes per neuron over a window, then scans for the argmax.
// Define SPIKE_CLASSIFIER_SATURATE_EN to make counters saturate instead of wrapping.
module spike_count_classifier #(
   parameter int NUM_OUTPUTS  = 1,
   parameter int COUNT_WIDTH  = 16,
   parameter int WINDOW_WIDTH = 16,
   parameter int IDX_WIDTH    = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_OUTPUTS-1:0]  spike_in,
   input  logic                    start,
   input  logic [WINDOW_WIDTH-1:0] window_len,
   output logic                    busy,
   output logic                    done,
   output logic [IDX_WIDTH-1:0]    class_out,
   output logic [COUNT_WIDTH-1:0]  class_count,
   input  logic [IDX_WIDTH-1:0]    cnt_addr,
   output logic [COUNT_WIDTH-1:0]  cnt_dout
);

   localparam int SCAN_W = IDX_WIDTH + 1;
   localparam logic [SCAN_W-1:0] SCAN_END = SCAN_W'(NUM_OUTPUTS);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_COUNT  = 2'd1;
   localparam logic [1:0] S_ARGMAX = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]              state;
   logic [WINDOW_WIDTH-1:0] rem;
   logic [SCAN_W-1:0]       scan_idx;
   logic [COUNT_WIDTH-1:0]  scan_cnt;
   logic [IDX_WIDTH-1:0]    best_idx;
   logic [COUNT_WIDTH-1:0]  best_cnt;
   logic [COUNT_WIDTH-1:0]  cnt_q [NUM_OUTPUTS];

   function automatic logic [COUNT_WIDTH-1:0] count_inc(input logic [COUNT_WIDTH-1:0] c,
                                                        input logic s);
`ifdef SPIKE_CLASSIFIER_SATURATE_EN
      return (s && (c != {COUNT_WIDTH{1'b1}})) ? c + COUNT_WIDTH'(1) : c;
`else
      return s ? c + COUNT_WIDTH'(1) : c;
`endif
   endfunction

   // Counter selected by the argmax scan pointer
   always_comb begin
      scan_cnt = '0;
      for (int i = 0; i < NUM_OUTPUTS; i++)
         if (scan_idx == SCAN_W'(i)) scan_cnt = cnt_q[i];
   end

   // Host readout; out-of-range addresses read as zero
   always_comb begin
      cnt_dout = '0;
      for (int i = 0; i < NUM_OUTPUTS; i++)
         if (cnt_addr == IDX_WIDTH'(i)) cnt_dout = cnt_q[i];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         rem         <= '0;
         scan_idx    <= '0;
         best_idx    <= '0;
         best_cnt    <= '0;
         class_out   <= '0;
         class_count <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= '0;
                  rem      <= window_len;
                  scan_idx <= '0;
                  busy     <= 1'b1;
                  state    <= (window_len == '0) ? S_ARGMAX : S_COUNT;
               end
            end
            S_COUNT: begin
               for (int i = 0; i < NUM_OUTPUTS; i++)
                  cnt_q[i] <= count_inc(cnt_q[i], spike_in[i]);
               rem <= rem - WINDOW_WIDTH'(1);
               if (rem == WINDOW_WIDTH'(1)) state <= S_ARGMAX;
            end
            S_ARGMAX: begin
               // One extra cycle after the last neuron to publish the result
               if (scan_idx == SCAN_END) begin
                  class_out   <= best_idx;
                  class_count <= best_cnt;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  if ((scan_idx == '0) || (scan_cnt > best_cnt)) begin
                     best_cnt <= scan_cnt;
                     best_idx <= scan_idx[IDX_WIDTH-1:0];
                  end
                  scan_idx <= scan_idx + SCAN_W'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spike_count_classifier.sv
// Scoreboard bench for spike_count_classifier (4 neurons, 4-bit counters).
module tb_spike_count_classifier;

   localparam int N  = 4;
   localparam int CW = 4;
   localparam int WW = 16;
   localparam int IW = 2;

   logic          clk;
   logic          rst;
   logic [N-1:0]  spike_in;
   logic          start;
   logic [WW-1:0] window_len;
   logic          busy;
   logic          done;
   logic [IW-1:0] class_out;
   logic [CW-1:0] class_count;
   logic [IW-1:0] cnt_addr;
   logic [CW-1:0] cnt_dout;

   spike_count_classifier #(
      .NUM_OUTPUTS (N),
      .COUNT_WIDTH (CW),
      .WINDOW_WIDTH(WW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spike_in   (spike_in),
      .start      (start),
      .window_len (window_len),
      .busy       (busy),
      .done       (done),
      .class_out  (class_out),
      .class_count(class_count),
      .cnt_addr   (cnt_addr),
      .cnt_dout   (cnt_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int cls;
      int cnt;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   n_done = 0;
   int   n_push = 0;
   int   prev_cls = 0;
   int   prev_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int model_count(input int n, input int w);
      int raw;
      raw = (n < w) ? n : w;
`ifdef SPIKE_CLASSIFIER_SATURATE_EN
      return (raw > (1 << CW) - 1) ? (1 << CW) - 1 : raw;
`else
      return raw % (1 << CW);
`endif
   endfunction

   task automatic check_counts(input string tag, input int ec[N]);
      for (int a = 0; a < N; a++) begin
         cnt_addr = IW'(a);
         #1;
         check_val($sformatf("%s_cnt%0d", tag, a), cnt_dout, ec[a]);
      end
   endtask

   // Scoreboard consumer: every done pulse pops one expected result
   always @(negedge clk) begin
      if (done === 1'b1) begin
         exp_t e;
         n_done++;
         check_val("busy_at_done", busy, 0);
         if (sb_q.size() == 0) begin
            check_val("spurious_done", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check_val("class_out", class_out, e.cls);
            check_val("class_count", class_count, e.cnt);
         end
      end
   end

   task automatic run_window(input string tag, input int w, input int n0, input int n1,
                             input int n2, input int n3, input int poke_j);
      int   n[N];
      int   ec[N];
      exp_t e;
      bit   seen;
      int   lat;
      n = '{n0, n1, n2, n3};
      e.cls = 0;
      e.cnt = 0;
      for (int i = 0; i < N; i++) begin
         ec[i] = model_count(n[i], w);
         if (i == 0 || ec[i] > e.cnt) begin
            e.cls = i;
            e.cnt = ec[i];
         end
      end
      sb_q.push_back(e);
      n_push++;

      @(negedge clk);
      start      = 1'b1;
      window_len = WW'(w);
      spike_in   = '1;
      seen = 1'b0;
      lat  = 0;
      for (int j = 1; j <= 200 && !seen; j++) begin
         @(negedge clk);
         start = (j == poke_j);
         if (j == 1) check_val({tag, "_busy"}, busy, 1);
         if (j == 2) begin
            check_val({tag, "_hold_cls"}, class_out, prev_cls);
            check_val({tag, "_hold_cnt"}, class_count, prev_cnt);
         end
         if (done === 1'b1) begin
            seen = 1'b1;
            lat  = j - 1;
         end else begin
            for (int i = 0; i < N; i++)
               spike_in[i] = (j - 1 < w) ? (j - 1 < n[i]) : 1'b1;
         end
      end
      spike_in = '0;
      start    = 1'b0;
      if (!seen) begin
         check_val({tag, "_timeout"}, 0, 1);
      end else begin
         check_val({tag, "_latency"}, lat, w + N + 1);
         check_counts(tag, ec);
      end
      prev_cls = e.cls;
      prev_cnt = e.cnt;
   endtask

   initial begin
      int zero[N];
      zero = '{0, 0, 0, 0};
      rst        = 1'b0;
      start      = 1'b0;
      window_len = '0;
      spike_in   = '0;
      cnt_addr   = '0;
      repeat (2) @(negedge clk);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_class_out", class_out, 0);
      check_val("rst_class_count", class_count, 0);
      check_counts("rst", zero);
      @(negedge clk);
      rst = 1'b1;

      run_window("basic", 10, 0, 3, 10, 0, 0);
      run_window("tie", 8, 0, 5, 0, 5, 0);
      run_window("zero_win", 0, 4, 4, 4, 4, 0);
      run_window("overflow", 20, 20, 6, 0, 0, 0);
      run_window("busy_start", 4, 1, 2, 3, 4, 7);
      run_window("back2back", 3, 3, 0, 0, 0, 0);

      // Reset in the third COUNT cycle, after two spike samples
      @(negedge clk);
      start      = 1'b1;
      window_len = WW'(10);
      spike_in   = '1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("midrst_busy", busy, 0);
      check_val("midrst_done", done, 0);
      check_val("midrst_class_out", class_out, 0);
      check_val("midrst_class_count", class_count, 0);
      check_counts("midrst", zero);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      spike_in = '0;
      prev_cls = 0;
      prev_cnt = 0;
      repeat (12) @(negedge clk);

      run_window("after_rst", 5, 1, 0, 2, 0, 0);

      repeat (3) @(negedge clk);
      check_val("done_count", n_done, n_push);
      check_val("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spike_count_classifier.md
# spike_count_classifier

Output decoder directly downstream of the IF network. Counts spikes per output neuron over a programmable window of timesteps, then scans the counters sequentially to find the winning neuron (argmax) and reports its index and spike count. Per-neuron counts stay readable through a small address/data port for host-side inspection.

## Interface

Parameters:
- NUM_OUTPUTS, 1: number of output neurons; equals the network's final-layer neuron count.
- COUNT_WIDTH, 16: width of each per-neuron spike counter.
- WINDOW_WIDTH, 16: width of the window-length input.
- IDX_WIDTH, (NUM_OUTPUTS>1 ? $clog2(NUM_OUTPUTS) : 1): width of neuron index fields. Derived; not set by the user.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- spike_in  in  NUM_OUTPUTS  spike vector from the network output, one bit per neuron per cycle.
- start  in  1  begins a classification window. Sampled only in IDLE.
- window_len  in  WINDOW_WIDTH  number of counting cycles. Latched when start is accepted.
- busy  out  1  high in COUNT and ARGMAX.
- done  out  1  one-cycle pulse when the result is valid.
- class_out  out  IDX_WIDTH  index of the winning neuron.
- class_count  out  COUNT_WIDTH  spike count of the winner.
- cnt_addr  in  IDX_WIDTH  readout neuron select.
- cnt_dout  out  COUNT_WIDTH  count of neuron cnt_addr. Combinational. Returns 0 if cnt_addr ≥ NUM_OUTPUTS.

## Operation

- States: IDLE, COUNT, ARGMAX, DONE.
- **IDLE:** start=1 does the following on the same edge:
  - clears all counters;
  - latches window_len into the remaining-cycles counter;
  - moves to COUNT, or to ARGMAX if window_len=0.
- start outside IDLE is ignored. No queueing.
- **COUNT:** every cycle, each count[i] += spike_in[i]. The remaining-cycles counter decrements; on the cycle it reaches 1, go to ARGMAX. Exactly window_len cycles of spike_in are sampled.
- **ARGMAX:**
  - Scan index k = 0..NUM_OUTPUTS-1, one neuron per cycle.
  - Best registers start at index 0, count[0].
  - Update the best only if count[k] > best (strict), so a tie resolves to the lowest index.
  - After k = NUM_OUTPUTS-1, go to DONE.
  - spike_in is ignored in ARGMAX and DONE.
- **DONE:** done=1 for exactly one cycle. class_out and class_count update on entry to DONE. Then return to IDLE.
- class_out and class_count hold their values until the next DONE, including across a new start.
- Counters are not cleared at DONE. cnt_dout shows the final-window counts until the next accepted start.
- **Reset** (rst=0, asynchronous, any state including mid-window) forces:
  - state IDLE;
  - all counters, best registers, class_out, class_count, busy, done = 0.
- Counter overflow behaviour is set by the configuration macro.

## Timing

- start accepted at edge t with window_len=W≥1:
  - COUNT samples spike_in at edges t+1 … t+W;
  - ARGMAX occupies t+W+1 … t+W+NUM_OUTPUTS;
  - done is high in the cycle after edge t+W+NUM_OUTPUTS+1.
- Total latency from start to done = W + NUM_OUTPUTS + 1 cycles.
- W=0: latency is NUM_OUTPUTS + 1. All counts are 0 and class_out=0.
- busy rises the cycle after start and falls when DONE is entered.
- The next start is accepted in the cycle after done, since the block is then back in IDLE.
- All outputs except cnt_dout are registered.

## Configuration

- SPIKE_CLASSIFIER_SATURATE_EN:
  - Defined: each counter saturates at 2^COUNT_WIDTH−1 and holds there.
  - Undefined: counters wrap modulo 2^COUNT_WIDTH.
- The ARGMAX comparison is unsigned in both cases.

## Test plan

- **Basic winner:** NUM_OUTPUTS=4, W=10. Neuron 2 spikes every cycle, neuron 1 spikes 3 times, others silent → done at start+15, class_out=2, class_count=10; cnt_dout at addr 1 = 3.
- **Tie:** neurons 1 and 3 each spike 5 times, W=8 → class_out=1, class_count=5.
- **Zero window:** W=0 with spikes present → done at start+5, class_out=0, class_count=0, all counts 0.
- **Overflow:** COUNT_WIDTH=4, W=20, neuron 0 spikes every cycle.
  - With SPIKE_CLASSIFIER_SATURATE_EN: class_count=15.
  - Without it: count[0]=4, and a second neuron spiking 6 times wins.
- **Reset mid-window:** drop rst in COUNT cycle 3 → busy=0, done never pulses, cnt_dout=0 for all addresses. A new start then completes normally.
- **Start while busy:** pulse start during ARGMAX → ignored; exactly one done. Back-to-back start in the cycle after done is accepted.
